// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, write widths,
// RISC-V load/store funct3 codes and the access-legality rules.
package load_store_unit_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_WAIT   = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic legal;
        if (is_store) begin
            legal = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
        end else begin
            legal = (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
                    (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
        end
        return legal;
    endfunction

    // funct3[1:0] encodes the access size for every legal load and store.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic write_width_t funct3_width(input logic [2:0] funct3);
        write_width_t w;
        case (funct3[1:0])
            2'b00:   w = WIDTH_BYTE;
            2'b01:   w = WIDTH_HALF;
            default: w = WIDTH_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Combinational load-result formatter: sign/zero-extends the low byte or
// half of a raw little-endian memory word according to the load funct3.
module load_extender
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            FUNCT3_LB:  ext_o = {{(XLEN-8){raw_i[7]}}, raw_i[7:0]};
            FUNCT3_LBU: ext_o = {{(XLEN-8){1'b0}}, raw_i[7:0]};
            FUNCT3_LH:  ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            FUNCT3_LHU: ext_o = {{(XLEN-16){1'b0}}, raw_i[15:0]};
            default:    ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: takes one load/store at a time, computes base+offset,
// drives the memory ports and returns an extended load value or a fault.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_store,
    input  logic [2:0]         req_funct3,
    input  logic [XLEN-1:0]    req_base,
    input  logic [XLEN-1:0]    req_offset,
    input  logic [XLEN-1:0]    req_store_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [XLEN-1:0]    resp_data,
    output logic               resp_fault,
    output logic               mem_wenable,
    output logic [XLEN-1:0]    mem_waddr,
    output write_width_t       mem_wwidth,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [XLEN-1:0]    mem_raddr,
    input  logic [XLEN-1:0]    mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_store_q, is_store_d;
    logic [XLEN-1:0]   store_data_q, store_data_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              resp_fault_q, resp_fault_d;

    logic [XLEN-1:0]   eff_addr;
    logic              req_fault;
    logic [XLEN-1:0]   load_value;

    assign eff_addr  = req_base + req_offset;
    assign req_fault = !funct3_legal(req_is_store, req_funct3) ||
                       is_misaligned(req_funct3, eff_addr[1:0]);

    load_extender #(.XLEN(XLEN)) u_load_extender (
        .funct3_i (funct3_q),
        .raw_i    (mem_rdata),
        .ext_o    (load_value)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LSU_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            is_store_q   <= 1'b0;
            store_data_q <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            store_data_q <= store_data_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        store_data_d = store_data_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    addr_d       = eff_addr;
                    funct3_d     = req_funct3;
                    is_store_d   = req_is_store;
                    store_data_d = req_store_data;
                    resp_data_d  = '0;
                    resp_fault_d = req_fault;
                    state_d      = req_fault ? LSU_RESP : LSU_ACCESS;
                end
            end
            LSU_ACCESS: state_d = is_store_q ? LSU_RESP : LSU_WAIT;
            LSU_WAIT: begin
                resp_data_d = load_value;
                state_d     = LSU_RESP;
            end
            LSU_RESP: begin
                if (resp_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // The write strobe is masked by reset so the hart's init muxing never sees a stray write.
    assign mem_wenable = (state_q == LSU_ACCESS) && is_store_q && !reset;
    assign mem_waddr   = addr_q;
    assign mem_wdata   = store_data_q;
    assign mem_wwidth  = funct3_width(funct3_q);
    assign mem_raddr   = addr_q;

    assign req_ready  = (state_q == LSU_IDLE);
    assign resp_valid = (state_q == LSU_RESP);
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the hart's decode/execute logic and the byte-addressable `memory` block.
- Accepts one load or store request at a time (effective address computed internally from base + immediate) and drives the memory write/read ports.
- For loads, returns the sign- or zero-extended rd value; for stores, returns a completion only.
- Flags misaligned and illegal-funct3 accesses as faults without touching memory.

Parameters:
- XLEN, 32, data/address width (matches isa_types XLEN).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_is_store  in  1  1 = store (funct3 SB/SH/SW), 0 = load (LB/LH/LW/LBU/LHU)
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_base  in  XLEN  rs1 value
- req_offset  in  XLEN  sign-extended I/S immediate
- req_store_data  in  XLEN  rs2 value
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_data  out  XLEN  extended load value (0 for stores/faults)
- resp_fault  out  1  misaligned or illegal funct3
- mem_wenable  out  1  memory write strobe
- mem_waddr  out  XLEN  memory write address
- mem_wwidth  out  write_width_t  byte/half/word
- mem_wdata  out  XLEN  write data, LSB-aligned
- mem_raddr  out  XLEN  memory read address
- mem_rdata  in  XLEN  little-endian word starting at mem_raddr, valid the cycle after mem_raddr is sampled

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP.
- Reset values: state = IDLE, resp_valid = 0, resp_data = 0, resp_fault = 0, mem_wenable = 0, req_ready = 1 next cycle.
- req_ready = 1 only in IDLE (combinational from state). Accept occurs at a posedge with req_valid && req_ready.
- On accept:
  - Register addr = req_base + req_offset (mod 2^XLEN, wrap ignored), funct3, is_store, store_data.
  - Fault if funct3 is illegal: loads allow {000,001,010,100,101}; stores allow {000,001,010}.
  - Fault if misaligned: half with addr[0] = 1, word with addr[1:0] != 0.
  - Fault: go to RESP with resp_fault = 1, resp_data = 0. Otherwise go to ACCESS.
- ACCESS, store:
  - mem_wenable = 1 for exactly this cycle; mem_waddr = addr; mem_wdata = store_data.
  - mem_wwidth: byte for SB, half for SH, word for SW.
  - Next state RESP, resp_data = 0.
- ACCESS, load: mem_raddr = addr, mem_wenable = 0; next state WAIT.
- WAIT:
  - mem_raddr held at addr.
  - At the edge, capture the extended mem_rdata into resp_data:
    - LB: sign-extend [7:0]; LBU: zero-extend [7:0]
    - LH: sign-extend [15:0]; LHU: zero-extend [15:0]
    - LW: [31:0]
  - Next state RESP.
- RESP:
  - resp_valid = 1; resp_data and resp_fault held stable until resp_valid && resp_ready.
  - Handshake moves to IDLE. No new accept in the same cycle.
- Latency, accept edge to resp_valid high: store 2 cycles, load 3 cycles, fault 1 cycle.
- mem_wenable is never asserted outside ACCESS, and never for loads or faults.
- mem_waddr/mem_wdata/mem_raddr are don't-care when unused; mem_raddr = addr in ACCESS/WAIT.
- Reset mid-operation (any state) → IDLE next edge. No write is issued after the reset edge, and a pending response is dropped.
- The hart's reset-time memory initialisation takes priority through its own muxing. The LSU issues no writes while reset is high.

Decomposition:
- isa_types additions:
  - lsu_state_t enum.
  - FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW constants, reusing existing ones where present.
  - write_width_t reused unchanged.
- Sub-module load_extender (combinational): funct3 + raw XLEN word → extended XLEN value. Instantiated once and unit-testable alone.

Test Plan:
- SW, base 0x60, offset 0, data 0x800000FF → 2 cycles after accept, ACCESS cycle shows mem_wenable = 1, waddr = 0x60, wwidth = word, wdata = 0x800000FF. resp_valid follows with fault = 0, data = 0. mem_wenable is high for exactly 1 cycle.
- LB at 0x63 with mem_rdata = 0x000000FF → resp_data = 0xFFFFFFFF. Repeat as LBU → 0x000000FF. resp_valid is high 3 cycles after accept.
- LH, base 0x62, offset 0xFFFFFFFE → mem_raddr = 0x60. With rdata = 0x00008001, resp_data = 0xFFFF8001. Repeat as LHU → 0x00008001.
- LW at 0x61, SH at 0x63, and load funct3 = 011 → each gives resp_fault = 1 one cycle after accept, resp_data = 0, mem_wenable never asserted.
- Back-pressure: hold resp_ready = 0 for 3 cycles during a load response → resp_valid, resp_data, resp_fault stable; req_ready = 0. After the handshake, IDLE and req_ready = 1.
- Assert reset while in WAIT, and separately in ACCESS for a store → IDLE next edge, resp_valid = 0, no mem_wenable pulse after the reset edge. A new request accepted after reset completes normally.
